// File: rtl/alarm_pkg.sv
// Shared constants for the alarm bank: STO word field positions, time limits,
// the default "every day" code and the edit FSM state encoding.
// No ports; imported by alarm_bank_setter and time_field_incr.
package alarm_pkg;

    // STO / CTI word layout: [15] on, [14:12] day, [11:7] hour,
    // [6:4] minute tens, [3:0] minute units. CTI is the same without bit 15.
    localparam int STO_W  = 16;
    localparam int STO_ON = 15;
    localparam int DAY_HI = 14;
    localparam int DAY_LO = 12;
    localparam int HR_HI  = 11;
    localparam int HR_LO  = 7;
    localparam int MT_HI  = 6;
    localparam int MT_LO  = 4;
    localparam int MU_HI  = 3;
    localparam int MU_LO  = 0;

    // Time limits. Minutes are BCD-like (tens, units), so the 59 limit is
    // split into its two digits for the carry chain.
    localparam int MIN_MAX       = 59;
    localparam int MIN_TENS_MAX  = MIN_MAX / 10;
    localparam int MIN_UNITS_MAX = MIN_MAX % 10;
    localparam int HOUR_MAX      = 23;
    localparam int DAY_LAST      = 6;
    localparam int DAY_ANY_DEF   = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EDIT  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/time_field_incr.sv
// Next value of the day/hour/minute fields of one STO word for one step of
// the IM/IH/ID buttons; purely combinational, zero latency, no backpressure.
// Ports: i_day/i_hour/i_tens/i_units current fields, i_im/i_ih/i_id step
// requests, o_* stepped fields.
module time_field_incr
    import alarm_pkg::*;
#(
    parameter bit         MIN_CARRY = 1'b0,
    parameter logic [2:0] DAY_ANY   = 3'(DAY_ANY_DEF)
) (
    input  logic [2:0] i_day,
    input  logic [4:0] i_hour,
    input  logic [2:0] i_tens,
    input  logic [3:0] i_units,
    input  logic       i_im,
    input  logic       i_ih,
    input  logic       i_id,
    output logic [2:0] o_day,
    output logic [4:0] o_hour,
    output logic [2:0] o_tens,
    output logic [3:0] o_units
);

    logic       w_min_wrap;
    logic [1:0] w_hr_step;
    logic [5:0] w_hr_sum;

    always_comb begin
        o_units    = i_units;
        o_tens     = i_tens;
        o_hour     = i_hour;
        o_day      = i_day;
        w_min_wrap = 1'b0;
        w_hr_step  = 2'd0;
        w_hr_sum   = 6'd0;

        // Minute digits. Using >= lets out-of-range loaded digits fall back
        // to 0 on the next step instead of counting up through garbage.
        if (i_im) begin
            if (i_units >= 4'(MIN_UNITS_MAX)) begin
                o_units = 4'd0;
                if (i_tens >= 3'(MIN_TENS_MAX)) begin
                    o_tens     = 3'd0;
                    w_min_wrap = 1'b1;
                end else begin
                    o_tens = i_tens + 3'd1;
                end
            end else begin
                o_units = i_units + 4'd1;
            end
        end

        // Hour can advance by up to 2 in one cycle (IH plus minute carry),
        // so 23 -> 01 is possible.
        w_hr_step = {1'b0, i_ih} + {1'b0, MIN_CARRY & w_min_wrap};
        w_hr_sum  = {1'b0, i_hour} + {4'd0, w_hr_step};
        if (w_hr_step != 2'd0) begin
            if (i_hour > 5'(HOUR_MAX)) begin
                o_hour = 5'd0;
            end else if (w_hr_sum > 6'(HOUR_MAX)) begin
                o_hour = 5'(w_hr_sum - 6'(HOUR_MAX + 1));
            end else begin
                o_hour = w_hr_sum[4:0];
            end
        end

        // Day sequence: 0..6, then the "every day" code, then back to 0.
        if (i_id) begin
            if (i_day == 3'(DAY_LAST)) begin
                o_day = DAY_ANY;
            end else if (i_day < 3'(DAY_LAST)) begin
                o_day = i_day + 3'd1;
            end else begin
                o_day = 3'd0;
            end
        end
    end

endmodule

// File: rtl/alarm_bank_setter.sv
// Alarm store: NUM_SLOTS STO words, single-slot edit buffer, per-slot minute match.
// Latency: STO and MATCH are registered, 1 cycle after SEL/buffer/CTI change.
// No backpressure; BUSY is high while an edit or its write-back is in progress.
// Ports: Clk, CLEAR (sync reset), CTI running time, SEL slot select, EDIT_EN,
// IM/IH/ID/TOF/LD_TIME/CLEAR_ST edit controls, COMMIT/CANCEL, STO view word,
// BUSY, MATCH per-slot pulse, ALARM = OR of MATCH.
module alarm_bank_setter
    import alarm_pkg::*;
#(
    parameter int NUM_SLOTS = 7,
    parameter int SLOT_W    = $clog2(NUM_SLOTS),
    parameter bit MIN_CARRY = 1'b0,
    parameter int DAY_ANY   = DAY_ANY_DEF
) (
    input  logic                 Clk,
    input  logic                 CLEAR,
    input  logic [14:0]          CTI,
    input  logic [SLOT_W-1:0]    SEL,
    input  logic                 EDIT_EN,
    input  logic                 IM,
    input  logic                 IH,
    input  logic                 ID,
    input  logic                 TOF,
    input  logic                 LD_TIME,
    input  logic                 CLEAR_ST,
    input  logic                 COMMIT,
    input  logic                 CANCEL,
    output logic [STO_W-1:0]     STO,
    output logic                 BUSY,
    output logic [NUM_SLOTS-1:0] MATCH,
    output logic                 ALARM
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [STO_W-1:0]     r_slot [NUM_SLOTS];
    logic [STO_W-1:0]     r_buf;
    logic [STO_W-1:0]     w_buf_nxt;
    logic [SLOT_W-1:0]    r_edit_slot;
    logic [SLOT_W-1:0]    w_edit_slot_nxt;
    logic                 w_slot_we;
    logic                 w_busy;
    logic [STO_W-1:0]     r_sto;
    logic [11:0]          r_prev_cti;
    logic                 r_prev_vld;
    logic                 w_tick;
    logic [NUM_SLOTS-1:0] r_match;
    logic [NUM_SLOTS-1:0] w_match_nxt;
    logic                 w_sel_vld;
    logic [STO_W-1:0]     w_sel_word;
    logic [2:0]           w_inc_day;
    logic [4:0]           w_inc_hour;
    logic [2:0]           w_inc_tens;
    logic [3:0]           w_inc_units;

    // Slot read mux; an out-of-range SEL matches no slot and reads as 0.
    always_comb begin
        w_sel_vld  = (int'(SEL) < NUM_SLOTS);
        w_sel_word = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (int'(SEL) == k) begin
                w_sel_word = r_slot[k];
            end
        end
    end

    time_field_incr #(
        .MIN_CARRY (MIN_CARRY),
        .DAY_ANY   (3'(DAY_ANY))
    ) u_buf_incr (
        .i_day   (r_buf[DAY_HI:DAY_LO]),
        .i_hour  (r_buf[HR_HI:HR_LO]),
        .i_tens  (r_buf[MT_HI:MT_LO]),
        .i_units (r_buf[MU_HI:MU_LO]),
        .i_im    (IM),
        .i_ih    (IH),
        .i_id    (ID),
        .o_day   (w_inc_day),
        .o_hour  (w_inc_hour),
        .o_tens  (w_inc_tens),
        .o_units (w_inc_units)
    );

    // Edit FSM next state and buffer update.
    always_comb begin
        w_state_nxt     = r_state;
        w_buf_nxt       = r_buf;
        w_edit_slot_nxt = r_edit_slot;
        w_slot_we       = 1'b0;
        w_busy          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (EDIT_EN && w_sel_vld) begin
                    w_state_nxt     = ST_EDIT;
                    w_edit_slot_nxt = SEL;
                    w_buf_nxt       = w_sel_word;
                end
            end
            ST_EDIT: begin
                w_busy = 1'b1;
                if (CANCEL) begin
                    w_state_nxt = ST_IDLE;
                end else if (COMMIT) begin
                    w_state_nxt = ST_WRITE;
                end else if (CLEAR_ST) begin
                    w_buf_nxt = '0;
                end else if (LD_TIME) begin
                    w_buf_nxt = {r_buf[STO_ON], CTI};
                end else begin
                    // IM/IH/ID/TOF all apply together in one cycle.
                    w_buf_nxt = {r_buf[STO_ON] ^ TOF, w_inc_day, w_inc_hour,
                                 w_inc_tens, w_inc_units};
                end
            end
            ST_WRITE: begin
                w_busy      = 1'b1;
                w_slot_we   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A minute tick is any change of hour/minute after the first sampled
    // cycle; day changes alone never fire an alarm.
    always_comb begin
        w_tick      = r_prev_vld && (CTI[HR_HI:MU_LO] != r_prev_cti);
        w_match_nxt = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            w_match_nxt[k] = w_tick && r_slot[k][STO_ON]
                && (r_slot[k][HR_HI:MU_LO] == CTI[HR_HI:MU_LO])
                && ((r_slot[k][DAY_HI:DAY_LO] == CTI[DAY_HI:DAY_LO])
                    || (r_slot[k][DAY_HI:DAY_LO] == 3'(DAY_ANY)));
            // Slot contents are changing under us this cycle.
            if ((r_state == ST_WRITE) && (int'(r_edit_slot) == k)) begin
                w_match_nxt[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (CLEAR) begin
            r_state     <= ST_IDLE;
            r_buf       <= '0;
            r_edit_slot <= '0;
            r_sto       <= '0;
            r_prev_cti  <= '0;
            r_prev_vld  <= 1'b0;
            r_match     <= '0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                r_slot[k] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_buf       <= w_buf_nxt;
            r_edit_slot <= w_edit_slot_nxt;
            r_sto       <= (r_state == ST_IDLE) ? w_sel_word : r_buf;
            r_prev_cti  <= CTI[HR_HI:MU_LO];
            r_prev_vld  <= 1'b1;
            r_match     <= w_match_nxt;
            if (w_slot_we) begin
                for (int k = 0; k < NUM_SLOTS; k++) begin
                    if (int'(r_edit_slot) == k) begin
                        r_slot[k] <= r_buf;
                    end
                end
            end
        end
    end

    assign STO   = r_sto;
    assign BUSY  = w_busy;
    assign MATCH = r_match;
    assign ALARM = |r_match;

endmodule

// File: tb/tb_alarm_bank_setter.sv
// Directed bench for alarm_bank_setter with MIN_CARRY=1 and 7 slots.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected STO words are hand-computed: {on, day[2:0], hour[4:0], tens[2:0], units[3:0]}.
module tb_alarm_bank_setter;

    logic        Clk      = 1'b0;
    logic        CLEAR    = 1'b1;
    logic [14:0] CTI      = '0;
    logic [2:0]  SEL      = 3'd2;
    logic        EDIT_EN  = 1'b0;
    logic        IM       = 1'b0;
    logic        IH       = 1'b0;
    logic        ID       = 1'b0;
    logic        TOF      = 1'b0;
    logic        LD_TIME  = 1'b0;
    logic        CLEAR_ST = 1'b0;
    logic        COMMIT   = 1'b0;
    logic        CANCEL   = 1'b0;
    logic [15:0] STO;
    logic        BUSY;
    logic [6:0]  MATCH;
    logic        ALARM;

    int n_chk  = 0;
    int n_pass = 0;

    alarm_bank_setter #(
        .NUM_SLOTS (7),
        .MIN_CARRY (1'b1),
        .DAY_ANY   (7)
    ) dut (
        .Clk      (Clk),
        .CLEAR    (CLEAR),
        .CTI      (CTI),
        .SEL      (SEL),
        .EDIT_EN  (EDIT_EN),
        .IM       (IM),
        .IH       (IH),
        .ID       (ID),
        .TOF      (TOF),
        .LD_TIME  (LD_TIME),
        .CLEAR_ST (CLEAR_ST),
        .COMMIT   (COMMIT),
        .CANCEL   (CANCEL),
        .STO      (STO),
        .BUSY     (BUSY),
        .MATCH    (MATCH),
        .ALARM    (ALARM)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic open_edit(input logic [2:0] slot);
        SEL     = slot;
        EDIT_EN = 1'b1;
        step();
        EDIT_EN = 1'b0;
    endtask

    task automatic commit_edit();
        COMMIT = 1'b1;
        step();          // EDIT -> WRITE
        COMMIT = 1'b0;
        step();          // WRITE -> IDLE, slot written
    endtask

    initial begin
        // Reset and idle view
        step(2);
        check("rst_sto",   STO,           16'h0000);
        check("rst_busy",  16'(BUSY),     16'h0000);
        check("rst_match", 16'(MATCH),    16'h0000);
        CLEAR = 1'b0;
        step();
        check("first_match", 16'(MATCH),  16'h0000);
        check("first_alarm", 16'(ALARM),  16'h0000);
        check("idle_sto2",   STO,         16'h0000);
        step();
        check("steady_match", 16'(MATCH), 16'h0000);

        // Edit slot 3: on, 7x hour, 30x minute -> on 07:30 day 0
        open_edit(3'd3);
        check("edit_busy", 16'(BUSY), 16'h0001);
        TOF = 1'b1; step(); TOF = 1'b0;
        IH  = 1'b1; step(7); IH = 1'b0;
        IM  = 1'b1; step(30); IM = 1'b0;
        step();
        check("edit_sto", STO, 16'h83B0);
        COMMIT = 1'b1; step(); COMMIT = 1'b0;
        check("write_busy", 16'(BUSY), 16'h0001);
        step();
        check("post_write_busy", 16'(BUSY), 16'h0000);
        step();
        check("slot3", STO, 16'h83B0);

        // Carry: load day 6 23:59, then IM+IH together -> 01:00 day 6
        open_edit(3'd4);
        CTI = 15'h6BD9;
        LD_TIME = 1'b1; step(); LD_TIME = 1'b0;
        step();
        check("ld_time", STO, 16'h6BD9);
        IM = 1'b1; IH = 1'b1; step(); IM = 1'b0; IH = 1'b0;
        step();
        check("carry_2359", STO, 16'h6080);
        ID = 1'b1; step(); ID = 1'b0;
        step();
        check("day_any", STO, 16'h7080);
        ID = 1'b1; step(); ID = 1'b0;
        step();
        check("day_wrap", STO, 16'h0080);
        CANCEL = 1'b1; step(); CANCEL = 1'b0;
        step();
        check("slot4_cancel", STO, 16'h0000);

        // Slot 1 = on, every day, 06:45
        open_edit(3'd1);
        CTI = 15'h6345;
        LD_TIME = 1'b1; step(); LD_TIME = 1'b0;
        ID = 1'b1; TOF = 1'b1; step(); ID = 1'b0; TOF = 1'b0;
        commit_edit();
        step();
        check("slot1", STO, 16'hF345);
        CTI = 15'h4344; step();
        check("match_pre", 16'(MATCH), 16'h0000);
        CTI = 15'h4345; step();
        check("match_hit", 16'(MATCH), 16'h0002);
        check("alarm_hit", 16'(ALARM), 16'h0001);
        step();
        check("match_hold", 16'(MATCH), 16'h0000);
        check("alarm_hold", 16'(ALARM), 16'h0000);
        step();
        check("match_hold2", 16'(MATCH), 16'h0000);

        // Same time with the on bit cleared -> no pulse
        open_edit(3'd1);
        TOF = 1'b1; step(); TOF = 1'b0;
        commit_edit();
        CTI = 15'h4344; step();
        CTI = 15'h4345; step();
        check("match_off", 16'(MATCH), 16'h0000);
        check("alarm_off", 16'(ALARM), 16'h0000);

        // Cancel leaves slot 0 untouched
        open_edit(3'd0);
        IM = 1'b1; step(3); IM = 1'b0;
        CANCEL = 1'b1; step(); CANCEL = 1'b0;
        check("cancel_busy", 16'(BUSY), 16'h0000);
        step();
        check("cancel_slot0", STO, 16'h0000);

        // Reset in the middle of an edit clears every slot
        open_edit(3'd0);
        IM = 1'b1; step(); IM = 1'b0;
        CLEAR = 1'b1; step(); CLEAR = 1'b0;
        check("clr_busy",  16'(BUSY),  16'h0000);
        check("clr_match", 16'(MATCH), 16'h0000);
        for (int s = 0; s < 7; s++) begin
            SEL = 3'(s);
            step();
            check($sformatf("clr_slot%0d", s), STO, 16'h0000);
        end

        // COMMIT + CANCEL + IM together: cancel wins
        open_edit(3'd2);
        IM = 1'b1; step(5); IM = 1'b0;
        commit_edit();
        step();
        check("slot2", STO, 16'h0005);
        open_edit(3'd2);
        COMMIT = 1'b1; CANCEL = 1'b1; IM = 1'b1;
        step();
        COMMIT = 1'b0; CANCEL = 1'b0; IM = 1'b0;
        check("prio_busy", 16'(BUSY), 16'h0000);
        step();
        check("prio_slot", STO, 16'h0005);

        // Out-of-range select reads 0 and cannot start an edit
        SEL = 3'd7;
        EDIT_EN = 1'b1; step(); EDIT_EN = 1'b0;
        check("bad_sel_busy", 16'(BUSY), 16'h0000);
        step();
        check("bad_sel_sto", STO, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
